// File: rtl/counter_sequencer.sv
// Wishbone-programmable sequencer for the user-area counter: it reloads the counter, enables it,
// detects the limit, then stops (one-shot) or reloads (periodic), and raises an interrupt.
module counter_sequencer #(
    parameter int          BITS      = 30,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] cnt_value,
    output logic            cnt_en,
    output logic            cnt_load,
    output logic [BITS-1:0] cnt_load_val,
    output logic            irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_ack;
    logic [31:0]     r_dat_o;
    logic [BITS-1:0] r_limit;
    logic [BITS-1:0] r_reload;
    logic            r_periodic;
    logic            r_irq_en;
    logic            r_done;
    logic            r_irq_pend;
    logic [15:0]     r_period_cnt;
    logic            r_cnt_load;
    logic [BITS-1:0] r_cnt_load_val;

    logic        w_hit;
    logic [1:0]  w_idx;
    logic        w_acc;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_start;
    logic        w_stop;
    logic        w_match;
    logic [31:0] w_limit32;
    logic [31:0] w_reload32;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Byte-lane merge of a write into a BITS-wide register.
    function automatic logic [BITS-1:0] merge_bytes(input logic [BITS-1:0] old_val,
                                                    input logic [31:0]     wdata,
                                                    input logic [3:0]      sel);
        logic [31:0] tmp;
        tmp = '0;
        tmp[BITS-1:0] = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
        end
        return tmp[BITS-1:0];
    endfunction

    assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_idx     = wbs_adr_i[3:2];
    assign w_acc     = w_hit & ~r_ack;
    assign w_wr      = w_acc & wbs_we_i;
    assign w_wr_ctrl = w_wr & (w_idx == 2'd0) & wbs_sel_i[0];
    assign w_wr_stat = w_wr & (w_idx == 2'd3);
    assign w_start   = w_wr_ctrl & wbs_dat_i[0];
    assign w_stop    = w_wr_ctrl & wbs_dat_i[1];
    assign w_match   = (cnt_value == r_limit);
    assign w_unused  = &{1'b0, wbs_adr_i[1:0]};

    always_comb begin
        w_limit32  = '0;
        w_reload32 = '0;
        w_limit32[BITS-1:0]  = r_limit;
        w_reload32[BITS-1:0] = r_reload;
        case (w_idx)
            2'd0:    w_rdata = {28'd0, r_irq_en, r_periodic, 2'b00};
            2'd1:    w_rdata = w_limit32;
            2'd2:    w_rdata = w_reload32;
            default: w_rdata = {r_period_cnt, 12'd0, r_irq_pend, r_done, r_state};
        endcase
    end

    // Wishbone handshake and software-owned configuration registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_limit    <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_irq_en   <= 1'b0;
        end else begin
            r_ack   <= w_acc;
            r_dat_o <= (w_acc & ~wbs_we_i) ? w_rdata : 32'd0;
            if (w_wr) begin
                case (w_idx)
                    2'd0: begin
                        if (wbs_sel_i[0]) begin
                            r_periodic <= wbs_dat_i[2];
                            r_irq_en   <= wbs_dat_i[3];
                        end
                    end
                    2'd1:    r_limit  <= merge_bytes(r_limit, wbs_dat_i, wbs_sel_i);
                    2'd2:    r_reload <= merge_bytes(r_reload, wbs_dat_i, wbs_sel_i);
                    default: ;
                endcase
            end
        end
    end

    // Sequencer FSM; status bits live here so a hardware set overrides a same-cycle W1C.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state        <= IDLE;
            r_done         <= 1'b0;
            r_irq_pend     <= 1'b0;
            r_period_cnt   <= '0;
            r_cnt_load     <= 1'b0;
            r_cnt_load_val <= '0;
        end else begin
            r_cnt_load <= 1'b0;
            if (w_wr_stat) begin
                r_period_cnt <= '0;
                if (wbs_sel_i[0] && wbs_dat_i[2]) r_done     <= 1'b0;
                if (wbs_sel_i[0] && wbs_dat_i[3]) r_irq_pend <= 1'b0;
            end
            if (w_stop) begin
                r_state <= IDLE;
            end else if (w_start) begin
                r_state        <= LOAD;
                r_cnt_load     <= 1'b1;
                r_cnt_load_val <= r_reload;
            end else begin
                case (r_state)
                    LOAD: r_state <= RUN;
                    RUN: begin
                        if (w_match) begin
                            r_irq_pend <= 1'b1;
                            if (r_periodic) begin
                                r_state        <= LOAD;
                                r_cnt_load     <= 1'b1;
                                r_cnt_load_val <= r_reload;
                                r_period_cnt   <= r_period_cnt + 16'd1;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_dat_o;
    assign cnt_load     = r_cnt_load;
    assign cnt_load_val = r_cnt_load_val;
    assign cnt_en       = (r_state == RUN) & ~w_match;
    assign irq          = r_irq_pend & r_irq_en;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: models the external counter and scoreboards register reads.
module tb_counter_sequencer;

    localparam int          BITS = 30;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     dat_i, adr;
    logic            ack;
    logic [31:0]     dat_o;
    logic [BITS-1:0] cnt_value;
    logic            cnt_en, cnt_load;
    logic [BITS-1:0] cnt_load_val;
    logic            irq;

    int          checks   = 0;
    int          failures = 0;
    int          en_cnt   = 0;
    logic [31:0] exp_q[$];

    counter_sequencer #(.BITS(BITS), .BASE_ADDR(BASE)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_dat_i   (dat_i),
        .wbs_adr_i   (adr),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .cnt_value   (cnt_value),
        .cnt_en      (cnt_en),
        .cnt_load    (cnt_load),
        .cnt_load_val(cnt_load_val),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    // External counter the sequencer drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_value <= '0;
        else if (cnt_load) cnt_value <= cnt_load_val;
        else if (cnt_en)   cnt_value <= cnt_value + 1'b1;
    end

    always @(negedge clk) if (cnt_en) en_cnt++;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, output logic acked, output logic [31:0] rdat);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        acked = 1'b0;
        rdat  = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rdat  = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic        acked;
        logic [31:0] rdat;
        wb_cycle(a, 1'b1, d, s, acked, rdat);
        check_val("write_ack", {31'd0, acked}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic        acked;
        logic [31:0] rdat;
        logic [31:0] e;
        exp_q.push_back(exp);
        wb_cycle(a, 1'b0, 32'd0, 4'hF, acked, rdat);
        e = exp_q.pop_front();
        if (acked) check_val(tag, rdat, e);
        else       check_val({tag, "_ack_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int e0;
        int loads;
        int cyc_at;
        logic        acked;
        logic [31:0] rdat;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", {31'd0, ack}, 32'd0);
        check_val("rst_dat", dat_o, 32'd0);
        check_val("rst_cnt_en", {31'd0, cnt_en}, 32'd0);
        check_val("rst_cnt_load", {31'd0, cnt_load}, 32'd0);
        check_val("rst_load_val", 32'(cnt_load_val), 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        wb_read(BASE + 32'h0, 32'h0, "rst_ctrl");
        wb_read(BASE + 32'h4, 32'h0, "rst_limit");
        wb_read(BASE + 32'h8, 32'h0, "rst_reload");
        wb_read(BASE + 32'hC, 32'h0, "rst_status");

        // One-shot 10 -> 15 with interrupt
        wb_write(BASE + 32'h8, 32'd10, 4'hF);
        wb_write(BASE + 32'h4, 32'd15, 4'hF);
        e0 = en_cnt;
        wb_write(BASE + 32'h0, 32'h9, 4'hF);
        check_val("os_load", {31'd0, cnt_load}, 32'd1);
        check_val("os_load_val", 32'(cnt_load_val), 32'd10);
        repeat (20) @(posedge clk);
        #1;
        check_val("os_en_cycles", 32'(en_cnt - e0), 32'd5);
        check_val("os_cnt_frozen", 32'(cnt_value), 32'd15);
        wb_read(BASE + 32'hC, 32'h0000_000F, "os_status");
        check_val("os_irq", {31'd0, irq}, 32'd1);
        wb_write(BASE + 32'hC, 32'h8, 4'hF);
        check_val("os_irq_clr", {31'd0, irq}, 32'd0);
        wb_read(BASE + 32'hC, 32'h0000_0007, "os_status_clr");

        // Periodic 0 -> 3, three completed periods
        wb_write(BASE + 32'hC, 32'h4, 4'hF);
        wb_write(BASE + 32'h8, 32'd0, 4'hF);
        wb_write(BASE + 32'h4, 32'd3, 4'hF);
        wb_write(BASE + 32'h0, 32'h5, 4'hF);
        loads  = 0;
        cyc_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (cnt_load) loads++;
            if (loads == 4) begin
                cyc_at = i;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("per_4th_load_cycle", 32'(cyc_at), 32'd15);
        wb_read(BASE + 32'hC, 32'h0003_000A, "per_status");
        check_val("per_irq_masked", {31'd0, irq}, 32'd0);

        // start+stop in the same write: stop wins
        wb_write(BASE + 32'h0, 32'h3, 4'hF);
        check_val("stop_cnt_en", {31'd0, cnt_en}, 32'd0);
        e0 = en_cnt;
        wb_write(BASE + 32'hC, 32'hC, 4'hF);
        wb_read(BASE + 32'hC, 32'h0, "stop_status");
        repeat (10) @(posedge clk);
        #1;
        check_val("stop_idle_en", 32'(en_cnt - e0), 32'd0);
        check_val("stop_idle_load", {31'd0, cnt_load}, 32'd0);

        // RELOAD == LIMIT: immediate match, never enabled
        wb_write(BASE + 32'h8, 32'd7, 4'hF);
        wb_write(BASE + 32'h4, 32'd7, 4'hF);
        e0 = en_cnt;
        wb_write(BASE + 32'h0, 32'h9, 4'hF);
        wb_read(BASE + 32'hC, 32'h0000_0002, "eq_status_run");
        wb_read(BASE + 32'hC, 32'h0000_000F, "eq_status_done");
        check_val("eq_irq", {31'd0, irq}, 32'd1);
        check_val("eq_en_never", 32'(en_cnt - e0), 32'd0);
        check_val("eq_cnt", 32'(cnt_value), 32'd7);

        // Out-of-window access and byte-lane write
        wb_cycle(BASE + 32'h10, 1'b0, 32'd0, 4'hF, acked, rdat);
        check_val("oow_ack", {31'd0, acked}, 32'd0);
        wb_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'b0001);
        wb_read(BASE + 32'h4, 32'h0000_00FF, "byte_limit");

        // Asynchronous reset while running
        wb_write(BASE + 32'h4, 32'h1000, 4'hF);
        wb_write(BASE + 32'h8, 32'd0, 4'hF);
        wb_write(BASE + 32'h0, 32'h1, 4'hF);
        repeat (5) @(posedge clk);
        #3;
        check_val("arst_running", {31'd0, cnt_en}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("arst_en_drop", {31'd0, cnt_en}, 32'd0);
        check_val("arst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wb_read(BASE + 32'hC, 32'h0, "arst_status");
        wb_read(BASE + 32'h4, 32'h0, "arst_limit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
